// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and divider helper for the UART character receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned START_MID  = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Rounded clk cycles per oversample tick.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO for received characters; DEPTH must be a power of 2 (>= 2).
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module char_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_char_rx.sv
// 16x-oversampling UART receiver feeding a character FIFO with a rate-limited we strobe.
// Define UART_RX_PARITY_EN for 8E1 frames; default build is 8N1.
module uart_char_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WE_GAP     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rx,
  output logic [7:0]                  cin,
  output logic                        we,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned GW  = $clog2(WE_GAP + 1);

  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;

  rx_state_t     state;
  rx_state_t     state_d;
  logic [SW-1:0] sub_cnt;
  logic [SW-1:0] sub_d;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_d;
  logic [7:0]    shreg;
  logic [7:0]    sh_d;
  logic          bit_mid;
  logic          push;
  logic          ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_err;
  logic          par_d;
`endif

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + DW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sub_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      sub_cnt <= sub_d;
      bit_cnt <= bit_d;
      shreg   <= sh_d;
`ifdef UART_RX_PARITY_EN
      par_err <= par_d;
`endif
    end
  end

  // sub_cnt wraps to 0 exactly at each bit midpoint after the start bit.
  assign bit_mid = (sub_cnt == SW'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state;
    sub_d   = sub_cnt;
    bit_d   = bit_cnt;
    sh_d    = shreg;
    push    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_err;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          sub_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sub_cnt == SW'(START_MID)) begin
            sub_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
`ifdef UART_RX_PARITY_EN
              par_d   = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            sub_d = sub_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          sub_d = sub_cnt + SW'(1);
          if (bit_mid) begin
            sh_d  = {rx_s, shreg[7:1]};
            bit_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          sub_d = sub_cnt + SW'(1);
          if (bit_mid) begin
            par_d   = rx_s ^ (^shreg);
            ferr_d  = rx_s ^ (^shreg);
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          sub_d = sub_cnt + SW'(1);
          if (bit_mid) begin
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              push = !par_err;
`else
              push = 1'b1;
`endif
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (shreg),
    .pop     (pop),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop = !fifo_empty && (gap_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cin       <= '0;
      we        <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      we        <= pop;
      frame_err <= ferr_d;
      overflow  <= push && fifo_full && !pop;
      if (pop) cin <= fifo_head;
      if (pop)                gap_cnt <= GW'(WE_GAP - 1);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed bench: u_dut runs at 160 clk/bit with WE_GAP=4; u_dut_ovf runs at 32 clk/bit
// with a long WE_GAP so the buffer/overflow scenario fits in a short run.
`timescale 1ns/1ps
module tb_uart_char_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD_A = 10_000;
  localparam int unsigned BAUD_B = 50_000;
  localparam int unsigned BIT_A  = 160;
  localparam int unsigned BIT_B  = 32;
  localparam int unsigned GAP_B  = 4000;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_a    = 1'b1;
  logic       rx_b    = 1'b1;
  logic [7:0] cin_a, cin_b;
  logic       we_a, we_b, fe_a, fe_b, ov_a, ov_b;
  logic [3:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  uart_char_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD_A), .FIFO_DEPTH(8), .WE_GAP(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx(rx_a), .cin(cin_a), .we(we_a),
    .frame_err(fe_a), .overflow(ov_a), .fifo_count(cnt_a)
  );

  uart_char_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD_B), .FIFO_DEPTH(8), .WE_GAP(GAP_B)) u_dut_ovf (
    .clk(clk), .reset_n(reset_n), .rx(rx_b), .cin(cin_b), .we(we_b),
    .frame_err(fe_b), .overflow(ov_b), .fifo_count(cnt_b)
  );

  int unsigned cyc = 0, push_cyc_a = 0, lat_a = 0;
  int unsigned we_n_a = 0, fe_n_a = 0, ov_n_a = 0;
  int unsigned we_n_b = 0, fe_n_b = 0, ov_n_b = 0;
  int unsigned last_we_b = 0, min_gap_b = 32'hFFFF_FFFF;
  logic [7:0]  log_a[$];
  logic [7:0]  log_b[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (u_dut.push) push_cyc_a <= cyc;
    if (we_a) begin
      we_n_a <= we_n_a + 1;
      lat_a  <= cyc - push_cyc_a;
      log_a.push_back(cin_a);
    end
    if (fe_a) fe_n_a <= fe_n_a + 1;
    if (ov_a) ov_n_a <= ov_n_a + 1;
    if (we_b) begin
      we_n_b <= we_n_b + 1;
      log_b.push_back(cin_b);
      if (we_n_b != 0 && (cyc - last_we_b) < min_gap_b) min_gap_b <= cyc - last_we_b;
      last_we_b <= cyc;
    end
    if (fe_b) fe_n_b <= fe_n_b + 1;
    if (ov_b) ov_n_b <= ov_n_b + 1;
  end

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input bit which, input logic v, input int unsigned n);
    if (which) rx_b = v;
    else       rx_a = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic idle(input bit which, input int unsigned n);
    drive_bit(which, 1'b1, n);
    #1;
  endtask

  task automatic send_byte(input bit which, input logic [7:0] b, input logic stop_v);
    int unsigned bp;
    bp = which ? BIT_B : BIT_A;
    drive_bit(which, 1'b0, bp);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i], bp);
`ifdef UART_RX_PARITY_EN
    drive_bit(which, ^b, bp);
`endif
    drive_bit(which, stop_v, bp);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    drive_bit(1'b0, 1'b0, BIT_A);
    for (int i = 0; i < 8; i++) drive_bit(1'b0, b[i], BIT_A);
    drive_bit(1'b0, ~(^b), BIT_A);
    drive_bit(1'b0, 1'b1, BIT_A);
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned w0, f0, o0, base;
    logic [31:0] got;

    repeat (5) @(posedge clk);
    #1;
    check_val("rst_cin", cin_a, 8'h00);
    check_val("rst_we", we_a, 1'b0);
    check_val("rst_frame_err", fe_a, 1'b0);
    check_val("rst_overflow", ov_a, 1'b0);
    check_val("rst_count", cnt_a, 4'd0);
    check_val("rst_count_b", cnt_b, 4'd0);
    @(negedge clk) reset_n = 1'b1;
    idle(0, 200);

    // Single good character
    w0 = we_n_a; f0 = fe_n_a; o0 = ov_n_a;
    send_byte(0, 8'h41, 1'b1);
    idle(0, 100);
    check_val("c41_we_pulses", we_n_a - w0, 1);
    check_val("c41_cin", cin_a, 8'h41);
    check_val("c41_count", cnt_a, 4'd0);
    check_val("c41_no_ferr", fe_n_a - f0, 0);
    check_val("c41_no_ovf", ov_n_a - o0, 0);
    check_val("c41_latency", lat_a, 2);

    // Short low glitch is rejected at the start-bit midpoint
    w0 = we_n_a; f0 = fe_n_a;
    drive_bit(0, 1'b0, 50);
    idle(0, 300);
    check_val("glitch_no_we", we_n_a - w0, 0);
    check_val("glitch_no_ferr", fe_n_a - f0, 0);
    check_val("glitch_state", 32'(u_dut.state), 32'(IDLE));

    // Bad stop bit, then recovery
    w0 = we_n_a; f0 = fe_n_a;
    send_byte(0, 8'h48, 1'b0);
    idle(0, 200);
    check_val("c48_ferr_pulses", fe_n_a - f0, 1);
    check_val("c48_no_we", we_n_a - w0, 0);
    check_val("c48_state_idle", 32'(u_dut.state), 32'(IDLE));
    w0 = we_n_a; f0 = fe_n_a;
    send_byte(0, 8'h49, 1'b1);
    idle(0, 100);
    check_val("c49_we_pulses", we_n_a - w0, 1);
    check_val("c49_cin", cin_a, 8'h49);
    check_val("c49_no_ferr", fe_n_a - f0, 0);

    // Reset in the middle of the data bits of 0x55
    drive_bit(0, 1'b0, BIT_A);
    drive_bit(0, 1'b1, BIT_A);
    drive_bit(0, 1'b0, BIT_A);
    drive_bit(0, 1'b1, BIT_A);
    drive_bit(0, 1'b0, BIT_A / 2);
    reset_n = 1'b0;
    rx_a    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("midrst_cin", cin_a, 8'h00);
    check_val("midrst_we", we_a, 1'b0);
    check_val("midrst_ferr", fe_a, 1'b0);
    check_val("midrst_ovf", ov_a, 1'b0);
    check_val("midrst_count", cnt_a, 4'd0);
    check_val("midrst_state", 32'(u_dut.state), 32'(IDLE));
    @(negedge clk) reset_n = 1'b1;
    idle(0, 200);
    w0 = we_n_a;
    send_byte(0, 8'h5A, 1'b1);
    idle(0, 100);
    check_val("c5a_we_pulses", we_n_a - w0, 1);
    check_val("c5a_cin", cin_a, 8'h5A);

`ifdef UART_RX_PARITY_EN
    w0 = we_n_a; f0 = fe_n_a;
    send_bad_parity(8'h03);
    idle(0, 200);
    check_val("par_bad_ferr", fe_n_a - f0, 1);
    check_val("par_bad_no_we", we_n_a - w0, 0);
    w0 = we_n_a; f0 = fe_n_a;
    send_byte(0, 8'h03, 1'b1);
    idle(0, 100);
    check_val("par_ok_we", we_n_a - w0, 1);
    check_val("par_ok_cin", cin_a, 8'h03);
    check_val("par_ok_no_ferr", fe_n_a - f0, 0);
`endif

    // Primer pop arms the long gap, then 10 back-to-back bytes fill and overflow the FIFO
    idle(1, 100);
    w0 = we_n_b; o0 = ov_n_b; f0 = fe_n_b; base = log_b.size();
    send_byte(1, 8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(1, 8'(i), 1'b1);
    idle(1, 100);
    check_val("ovf_count_full", cnt_b, 4'd8);
    check_val("ovf_pulses", ov_n_b - o0, 2);
    check_val("ovf_we_primer_only", we_n_b - w0, 1);
    got = (base < log_b.size()) ? 32'(log_b[base]) : 32'hDEAD;
    check_val("ovf_primer_cin", got, 8'hA5);
    for (int k = 0; k < 40000 && (we_n_b - w0) < 9; k++) @(posedge clk);
    idle(1, 10);
    check_val("ovf_drain_we", we_n_b - w0, 9);
    for (int i = 0; i < 8; i++) begin
      got = (base + 1 + i < log_b.size()) ? 32'(log_b[base + 1 + i]) : 32'hDEAD;
      check_val($sformatf("ovf_order_%0d", i), got, i);
    end
    check_val("ovf_we_gap", min_gap_b, GAP_B);
    check_val("ovf_drain_count", cnt_b, 4'd0);
    check_val("ovf_pulses_final", ov_n_b - o0, 2);
    check_val("ovf_no_ferr", fe_n_b - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_char_rx.md
UART_CHAR_RX -- requirements
Module: uart_char_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial line rate.
REQ-003 Parameter FIFO_DEPTH, default 8, received-character buffer entries (power of 2).
REQ-004 Parameter WE_GAP, default 4, minimum clk cycles between successive we pulses.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 rx  input  1  asynchronous serial line, 8N1 (8E1 with parity option), idle high.
REQ-008 cin  output  8  character to the character feeder, held between pops.
REQ-009 we  output  1  one-cycle strobe: cin valid this cycle.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overflow  output  1  one-cycle pulse: good character dropped, FIFO full.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 rx SHALL pass a 2-flop synchroniser; only the synchronised value is used.
REQ-014 A 16x oversample tick SHALL be generated every DIV=round(CLK_HZ/(16*BAUD)) clk cycles, free-running.
REQ-015 FSM states: IDLE, START, DATA, PARITY (option only), STOP, WAIT_HIGH.
REQ-016 IDLE->START on synchronised rx falling to 0; tick sub-counter cleared.
REQ-017 START: at sub-count 7, rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, nothing reported).
REQ-018 DATA: sample every 16 ticks from start-bit midpoint, LSB first, 8 bits, then PARITY or STOP.
REQ-019 STOP: rx=1 at midpoint -> push byte, go IDLE; rx=0 -> frame_err pulse, discard, go WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE only after rx sampled 1 (prevents break re-triggering).
REQ-021 Push while FIFO full SHALL drop the new byte, keep contents, pulse overflow.
REQ-022 Pop when FIFO non-empty and gap counter is 0: cin <= head, we=1 for exactly one cycle, gap counter loaded with WE_GAP-1.
REQ-023 Latency: push into empty FIFO with gap expired -> we asserted 2 clk cycles later.
REQ-024 Simultaneous push and pop SHALL both occur; fifo_count unchanged; full FIFO accepts the push.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.

Reset
REQ-026 reset_n=0: FSM IDLE, FIFO empty, fifo_count=0, cin=0x00, we=0, frame_err=0, overflow=0, gap counter 0, synchroniser flops 1.
REQ-027 Reset mid-frame SHALL abandon the frame; after release the next falling edge begins a new frame.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit; mismatch -> frame_err pulse, byte discarded, STOP still checked then IDLE/WAIT_HIGH.
REQ-029 Macro undefined: frame is 8N1, PARITY state and parity logic absent, DATA goes directly to STOP.

Structure
REQ-030 Shared package uart_pkg: FSM state enum, OVERSAMPLE=16, START_MID=7 constants.
REQ-031 FIFO SHALL be sub-module char_fifo (parameterised depth/width, push/pop/full/empty/count); the rest lives in uart_char_rx.

Verification (CLK_HZ=1_600_000, BAUD=10_000, DIV=10, 160 clk/bit)
REQ-032 Send 0x41 8N1 -> one we pulse, cin=0x41, fifo_count returns to 0, no error pulses.
REQ-033 rx low 50 clk then high -> no we, no frame_err, FSM back in IDLE.
REQ-034 Send 0x48 with stop bit 0 -> frame_err pulses once, no we; next 0x49 received normally.
REQ-035 Back-to-back 10 bytes with pop path held off (WE_GAP large) -> 8 buffered, overflow pulses twice, then 0x00..0x07 emitted in order, we pulses >=WE_GAP apart.
REQ-036 reset_n low mid-DATA of 0x55 -> all outputs reset values; following 0x5A received correctly.
REQ-037 With UART_RX_PARITY_EN: 0x03 with parity 1 -> frame_err, no we; with parity 0 -> we, cin=0x03.
